// File: rtl/mem_pkg.sv
// Shared encodings for the pipelined memory-access stage.
// Includes memory-op codes, funct3 size selectors, FSM states and size helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] SEL_B   = 3'b000;
  localparam logic [2:0] SEL_H   = 3'b001;
  localparam logic [2:0] SEL_W   = 3'b010;
  localparam logic [2:0] SEL_D   = 3'b011;
  localparam logic [2:0] SEL_BU  = 3'b100;
  localparam logic [2:0] SEL_HU  = 3'b101;
  localparam logic [2:0] SEL_WU  = 3'b110;
  localparam logic [2:0] SEL_BAD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_HOLD
  } state_e;

  // Access size in bytes; this is also the number of strobe bits set.
  function automatic int unsigned strb_width(input logic [2:0] sel);
    return 32'd1 << sel[1:0];
  endfunction

  function automatic logic size_legal(input logic [2:0] sel, input int xlen);
    return !((sel == SEL_BAD) || ((xlen == 32) && ((sel == SEL_D) || (sel == SEL_WU))));
  endfunction

endpackage

// File: rtl/pipe_memory_access_if.sv
// Variable-latency memory bus between the memory stage (master) and memory (slave).
// Read data is valid in the same cycle as bus_ack.
interface pipe_memory_access_if #(
  parameter int XLEN = 32
);
  logic              bus_req;
  logic [XLEN/8-1:0] bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store shift/strobes, misalignment check,
// and load lane extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [OW-1:0]     st_off,
  input  logic [2:0]        st_sel,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN/8-1:0] st_we,
  output logic [XLEN-1:0]   st_wdata,
  output logic              misalign,
  input  logic [OW-1:0]     ld_off,
  input  logic [2:0]        ld_sel,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);
  localparam int NB = XLEN / 8;

  logic [NB-1:0]   base_we;
  logic [OW-1:0]   low_mask;
  logic [XLEN-1:0] ld_shift;

  always_comb begin
    low_mask = OW'(strb_width(st_sel) - 32'd1);
    misalign = !size_legal(st_sel, XLEN) || ((st_off & low_mask) != '0);
    for (int unsigned i = 0; i < NB; i++) begin
      base_we[i] = (i < strb_width(st_sel));
    end
    st_we    = base_we << st_off;
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    // NOTE: default assigned before the case so no path leaves ld_data unassigned (no latch).
    ld_data  = ld_shift;
    case (ld_sel)
      SEL_B:   ld_data = XLEN'($signed(ld_shift[7:0]));
      SEL_H:   ld_data = XLEN'($signed(ld_shift[15:0]));
      SEL_W:   ld_data = XLEN'($signed(ld_shift[31:0]));
      SEL_BU:  ld_data = XLEN'(ld_shift[7:0]);
      SEL_HU:  ld_data = XLEN'(ld_shift[15:0]);
      SEL_WU:  ld_data = XLEN'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/pipe_memory_access.sv
// Registered, handshaked memory-access stage between EX and WB.
// Drives a req/ack memory bus with timeout and carries WB sideband alongside the result.
module pipe_memory_access
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mem_op,
  input  logic [2:0]        mem_sel,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [1:0]        wb_sel_in,
  input  logic [XLEN-1:0]   immediate_in,
  input  logic [XLEN-1:0]   pc_next_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_we_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   mem_rdata,
  output logic [1:0]        wb_sel_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [XLEN-1:0]   immediate_out,
  output logic [XLEN-1:0]   pc_next_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_we_out,
  output logic              misalign_exc,
  output logic              bus_err,
  pipe_memory_access_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [2:0]        sel_q, sel_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pcn_q, pcn_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              reg_we_q, reg_we_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic [NB-1:0]     st_we;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_data;
  logic              st_mis;
  logic              accept;
  logic              is_mem;
  mem_op_e           op;

  mem_lane_align #(.XLEN(XLEN), .OW(OW)) u_align (
    .st_off   (alu_result[OW-1:0]),
    .st_sel   (mem_sel),
    .st_data  (rs2_data),
    .st_we    (st_we),
    .st_wdata (st_wdata),
    .misalign (st_mis),
    .ld_off   (addr_q[OW-1:0]),
    .ld_sel   (sel_q),
    .ld_rdata (bus.bus_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wb_sel_d = wb_sel_q;
    imm_d    = imm_q;
    pcn_d    = pcn_q;
    rd_d     = rd_q;
    reg_we_d = reg_we_q;
    mis_d    = mis_q;
    err_d    = err_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    op       = mem_op_e'(mem_op);
    is_mem   = (op == MEM_LOAD) || (op == MEM_STORE);

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !flush;
      end
      ST_BUS: begin
        // A flushed access still finishes its bus handshake; only its result is discarded.
        if (flush) drop_d = 1'b1;
        if (bus.bus_ack) begin
          if (we_q == '0) rdata_d = ld_data;
          state_d = (drop_q || flush) ? ST_IDLE : ST_HOLD;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          err_d    = 1'b1;
          reg_we_d = 1'b0;
          state_d  = (drop_q || flush) ? ST_IDLE : ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        in_ready = out_ready;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          accept = in_valid;
          if (!in_valid) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      sel_d    = mem_sel;
      addr_d   = alu_result;
      wdata_d  = st_wdata;
      rdata_d  = '0;
      cnt_d    = '0;
      drop_d   = 1'b0;
      err_d    = 1'b0;
      mis_d    = is_mem && st_mis;
      we_d     = ((op == MEM_STORE) && !st_mis) ? st_we : '0;
      wb_sel_d = wb_sel_in;
      imm_d    = immediate_in;
      pcn_d    = pc_next_in;
      rd_d     = rd_in;
      reg_we_d = reg_we_in && !(is_mem && st_mis);
      state_d  = (is_mem && !st_mis) ? ST_BUS : ST_HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wb_sel_q <= '0;
      imm_q    <= '0;
      pcn_q    <= '0;
      rd_q     <= '0;
      reg_we_q <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wb_sel_q <= wb_sel_d;
      imm_q    <= imm_d;
      pcn_q    <= pcn_d;
      rd_q     <= rd_d;
      reg_we_q <= reg_we_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  assign out_valid      = (state_q == ST_HOLD);
  assign mem_rdata      = rdata_q;
  assign wb_sel_out     = wb_sel_q;
  assign alu_result_out = addr_q;
  assign immediate_out  = imm_q;
  assign pc_next_out    = pcn_q;
  assign rd_out         = rd_q;
  assign reg_we_out     = reg_we_q;
  assign misalign_exc   = mis_q;
  assign bus_err        = err_q;

  assign bus.bus_req    = (state_q == ST_BUS);
  assign bus.bus_we     = we_q;
  assign bus.bus_addr   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign bus.bus_wdata  = wdata_q;

endmodule

// File: doc/pipe_memory_access.md
Name: pipe_memory_access

Overview:
Registered, handshaked memory-access stage for the pipelined core. It generalises the single-cycle memory stage to XLEN 32/64 and a variable-latency bus with a req/ack handshake and timeout. It performs load/store byte-lane alignment, sign/zero extension and misalignment detection. It sits between EX and WB, carrying writeback sideband fields through with the memory result.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; 64 enables LD/SD/LWU.
REG_AW, 5, register index width.
TIMEOUT, 255, bus wait cycles before bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX has a valid op
in_ready  out  1  stage can accept the op
mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mem_sel  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
alu_result  in  XLEN  effective address / passthrough
rs2_data  in  XLEN  store data
wb_sel_in, immediate_in, pc_next_in, rd_in, reg_we_in  in  2/XLEN/XLEN/REG_AW/1  WB sideband
flush  in  1  kill the held op
out_valid  out  1  result valid to WB
out_ready  in  1  WB accepts
mem_rdata  out  XLEN  extended load data
wb_sel_out, alu_result_out, immediate_out, pc_next_out, rd_out, reg_we_out  out  registered sideband
misalign_exc  out  1  registered with out_valid
bus_err  out  1  timeout, registered with out_valid
bus_req  out  1  bus request
bus_we  out  XLEN/8  byte write strobes; all zero means read
bus_addr  out  XLEN  address aligned to XLEN/8
bus_wdata  out  XLEN  lane-shifted store data
bus_ack  in  1  bus completes; rdata valid the same cycle
bus_rdata  in  XLEN  read data

Behaviour:
- Reset (async, rst=1): FSM to IDLE; out_valid, bus_req, misalign_exc and bus_err go to 0; bus_we goes to 0; all data registers go to 0.
- FSM states: IDLE, BUS, HOLD.
- IDLE: in_ready=1.
  - On in_valid, capture all inputs.
  - mem_op none, or misaligned: go to HOLD; out_valid=1 next cycle (1-cycle latency).
  - Otherwise go to BUS with bus_req=1 the next cycle.
- Misaligned means: H with addr[0]≠0; W/WU with addr[1:0]≠0; D with addr[2:0]≠0. Misaligned ops never assert bus_req. They set misalign_exc=1 and force reg_we_out=0.
- Illegal size: sel 011/110 when XLEN=32, or 111 at any width. Treat as misaligned.
- BUS: bus_req, bus_addr, bus_we and bus_wdata stay stable until bus_ack.
  - On bus_ack, latch the extended rdata and go to HOLD.
  - The wait counter increments each BUS cycle. When it reaches TIMEOUT without ack: drop bus_req, set bus_err=1, force reg_we_out=0, go to HOLD.
- HOLD: out_valid=1 and all outputs stable.
  - On out_ready: if in_valid, accept the next op in the same cycle (in_ready=out_ready in HOLD); otherwise go to IDLE.
  - This gives back-to-back throughput of 1 op/cycle for non-memory ops.
- Load lane select: byte offset = addr[log2(XLEN/8)-1:0]. Shift rdata right by 8*offset, then sign- or zero-extend per mem_sel.
- Store: bus_wdata = rs2_data replicated/shifted to the lane. bus_we has a 1/2/4/8-bit mask at the offset.
- flush:
  - Drops any op in HOLD (out_valid=0 next cycle).
  - In BUS, a store still completes the handshake, then its result is dropped. A load also completes and its result is dropped; bus_req never deasserts before ack or timeout.
  - In IDLE, flush with in_valid rejects the input.
- The ack cycle coinciding with the timeout cycle counts as ack.

Decomposition:
- Package mem_pkg: mem_op encodings, mem_sel funct3 constants, FSM state enum, and a function for strobe-mask width.
- Sub-module mem_lane_align: combinational store shift/strobe, load extract/extend, and misalign flag, parametrised by XLEN.
- The FSM, counter and pipeline registers live in the top module.

Test Plan:
- XLEN=32; LW addr 0x100; ack after 3 cycles with rdata 0xDEADBEEF. Expect: bus_req held 3 cycles, bus_we=0000, mem_rdata=0xDEADBEEF, out_valid one cycle after ack.
- LB addr 0x103, rdata 0x80xxxxxx. Expect mem_rdata=0xFFFFFF80. LBU gives 0x00000080. LH addr 0x102, rdata 0x8001xxxx gives 0xFFFF8001.
- SB addr 0x201, rs2=0x000000AB. Expect bus_we=0010, bus_wdata[15:8]=0xAB, bus_addr=0x200. SH addr 0x202 gives bus_we=1100.
- SW addr 0x102. Expect misalign_exc=1, reg_we_out=0, no bus_req, out_valid after 1 cycle.
- TIMEOUT=4, bus_ack never asserted. Expect bus_req for 4 cycles, then bus_err=1 with out_valid. Also assert rst mid-BUS: bus_req drops immediately.
- Back-to-back ALU ops with out_ready=1 stream at 1/cycle. Hold out_ready=0 for 2 cycles: outputs stay stable and in_ready=0. With XLEN=64, LD addr 0x8 returns the full 64-bit rdata.
